// File: rtl/fft_pkg.sv
// Shared defaults, lane/tag indices and FSM state type for the FFT frame controller.
package fft_pkg;

    localparam int unsigned NBITS_DEFAULT     = 10;
    localparam int unsigned NBITS_OUT_DEFAULT = 10;
    localparam int unsigned N_DEFAULT         = 128;
    localparam int unsigned LAT_DEFAULT       = 7;

    // Lane order inside s_data / m_data, lane 0 in the LSBs.
    localparam int unsigned LANE_IN0_UP   = 0;
    localparam int unsigned LANE_IN0_DOWN = 1;
    localparam int unsigned LANE_IN1_UP   = 2;
    localparam int unsigned LANE_IN1_DOWN = 3;

    // Beat tag bit positions {v, sof, eof}.
    localparam int unsigned TAG_EOF = 0;
    localparam int unsigned TAG_SOF = 1;
    localparam int unsigned TAG_V   = 2;
    localparam int unsigned TAG_W   = 3;

    typedef enum logic {
        StIdle,
        StLoad
    } fsmState_t;

endpackage

// File: rtl/fft_tag_pipe.sv
// Fixed-depth shift register carrying the beat tag alongside the topfft datapath.
module fft_tag_pipe
    import fft_pkg::*;
#(
    parameter int unsigned LAT = LAT_DEFAULT,
    parameter int unsigned W   = TAG_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] tagIn,
    output logic [W-1:0] tagOut
);

    generate
        if (LAT == 0) begin : genBypass
            assign tagOut = tagIn;
        end else begin : genPipe
            logic [W-1:0] stageQ [LAT];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < int'(LAT); i++) begin
                        stageQ[i] <= '0;
                    end
                end else begin
                    stageQ[0] <= tagIn;
                    for (int i = 1; i < int'(LAT); i++) begin
                        stageQ[i] <= stageQ[i-1];
                    end
                end
            end

            assign tagOut = stageQ[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frames a 4-lane beat stream into fixed N/4-beat topfft frames and re-tags the output.
// Optional status outputs (underrun, frame_cnt) are built when FFT_FRAME_CTRL_STATUS_EN is defined.
module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned NBITS     = NBITS_DEFAULT,
    parameter int unsigned NBITS_out = NBITS_OUT_DEFAULT,
    parameter int unsigned N         = N_DEFAULT,
    parameter int unsigned LAT       = LAT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [8*NBITS-1:0]     s_data,
    output logic [2*NBITS-1:0]     fftIn0_up,
    output logic [2*NBITS-1:0]     fftIn0_down,
    output logic [2*NBITS-1:0]     fftIn1_up,
    output logic [2*NBITS-1:0]     fftIn1_down,
    input  logic [2*NBITS_out-1:0] fftOut0_up,
    input  logic [2*NBITS_out-1:0] fftOut0_down,
    input  logic [2*NBITS_out-1:0] fftOut1_up,
    input  logic [2*NBITS_out-1:0] fftOut1_down,
    output logic                   m_valid,
    output logic                   m_sof,
    output logic                   m_eof,
    output logic [8*NBITS_out-1:0] m_data
`ifdef FFT_FRAME_CTRL_STATUS_EN
    ,
    output logic                   underrun,
    output logic [15:0]            frame_cnt
`endif
);

    localparam int unsigned BEATS = N / 4;
    localparam int unsigned LW    = 2 * NBITS;
    localparam int unsigned CNTW  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNTW-1:0] LAST = CNTW'(BEATS - 1);

    fsmState_t         stateQ, stateD;
    logic [CNTW-1:0]   cntQ, cntD;
    logic [8*NBITS-1:0] fftInQ, fftInD;
    logic [TAG_W-1:0]  tagQ, tagD, tagOut;
    logic              beatFire;
    logic              takeData;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= StIdle;
            cntQ   <= '0;
            fftInQ <= '0;
            tagQ   <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            fftInQ <= fftInD;
            tagQ   <= tagD;
        end
    end

    // In LOAD every cycle is a frame beat; a missing s_valid becomes a zero beat.
    always_comb begin
        stateD   = stateQ;
        cntD     = cntQ;
        s_ready  = 1'b0;
        beatFire = 1'b0;
        takeData = 1'b0;
        unique case (stateQ)
            StIdle: begin
                s_ready  = en & ~rst;
                beatFire = s_valid & en;
                takeData = s_valid & en;
            end
            StLoad: begin
                s_ready  = 1'b1;
                beatFire = 1'b1;
                takeData = s_valid;
            end
            default: ;
        endcase
        if (beatFire) begin
            if (cntQ == LAST) begin
                cntD   = '0;
                stateD = StIdle;
            end else begin
                cntD   = cntQ + CNTW'(1);
                stateD = StLoad;
            end
        end
    end

    always_comb begin
        fftInD         = takeData ? s_data : '0;
        tagD           = '0;
        tagD[TAG_V]    = beatFire;
        tagD[TAG_SOF]  = beatFire & (cntQ == '0);
        tagD[TAG_EOF]  = beatFire & (cntQ == LAST);
    end

    assign fftIn0_up   = fftInQ[LANE_IN0_UP*LW   +: LW];
    assign fftIn0_down = fftInQ[LANE_IN0_DOWN*LW +: LW];
    assign fftIn1_up   = fftInQ[LANE_IN1_UP*LW   +: LW];
    assign fftIn1_down = fftInQ[LANE_IN1_DOWN*LW +: LW];

    fft_tag_pipe #(
        .LAT (LAT),
        .W   (TAG_W)
    ) uTagPipe (
        .clk    (clk),
        .rst    (rst),
        .tagIn  (tagQ),
        .tagOut (tagOut)
    );

    assign m_valid = tagOut[TAG_V];
    assign m_sof   = tagOut[TAG_V] & tagOut[TAG_SOF];
    assign m_eof   = tagOut[TAG_V] & tagOut[TAG_EOF];
    assign m_data  = {fftOut1_down, fftOut1_up, fftOut0_down, fftOut0_up};

`ifdef FFT_FRAME_CTRL_STATUS_EN
    logic        underrunQ;
    logic [15:0] frameCntQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrunQ <= 1'b0;
            frameCntQ <= '0;
        end else begin
            if (stateQ == StLoad && !s_valid) begin
                underrunQ <= 1'b1;
            end
            if (m_valid && m_eof) begin
                frameCntQ <= frameCntQ + 16'd1;
            end
        end
    end

    assign underrun  = underrunQ;
    assign frame_cnt = frameCntQ;
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl; topfft is modelled as a LAT-cycle delay of fftIn*.
module tb_fft_frame_ctrl;

    localparam int NB   = 10;
    localparam int NBO  = 10;
    localparam int NPTS = 128;
    localparam int LATC = 7;
    localparam int DW   = 8 * NB;
    localparam int OW   = DW + 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic s_ready;
    logic [2*NB-1:0] fftIn0_up, fftIn0_down, fftIn1_up, fftIn1_down;
    logic [2*NBO-1:0] fftOut0_up, fftOut0_down, fftOut1_up, fftOut1_down;
    logic m_valid, m_sof, m_eof;
    logic [8*NBO-1:0] m_data;
`ifdef FFT_FRAME_CTRL_STATUS_EN
    logic underrun;
    logic [15:0] frame_cnt;
`endif

    int checks = 0;
    int failures = 0;

    fft_frame_ctrl #(
        .NBITS     (NB),
        .NBITS_out (NBO),
        .N         (NPTS),
        .LAT       (LATC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .fftIn0_up    (fftIn0_up),
        .fftIn0_down  (fftIn0_down),
        .fftIn1_up    (fftIn1_up),
        .fftIn1_down  (fftIn1_down),
        .fftOut0_up   (fftOut0_up),
        .fftOut0_down (fftOut0_down),
        .fftOut1_up   (fftOut1_up),
        .fftOut1_down (fftOut1_down),
        .m_valid      (m_valid),
        .m_sof        (m_sof),
        .m_eof        (m_eof),
        .m_data       (m_data)
`ifdef FFT_FRAME_CTRL_STATUS_EN
        ,
        .underrun     (underrun),
        .frame_cnt    (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] topPipe [LATC];
    always @(posedge clk) begin
        topPipe[0] <= {fftIn1_down, fftIn1_up, fftIn0_down, fftIn0_up};
        for (int i = 1; i < LATC; i++) topPipe[i] <= topPipe[i-1];
    end
    assign fftOut0_up   = topPipe[LATC-1][0*2*NBO +: 2*NBO];
    assign fftOut0_down = topPipe[LATC-1][1*2*NBO +: 2*NBO];
    assign fftOut1_up   = topPipe[LATC-1][2*2*NBO +: 2*NBO];
    assign fftOut1_down = topPipe[LATC-1][3*2*NBO +: 2*NBO];

    // Lane l carries {l+1, beat}, so lanes differ and real data is never zero.
    function automatic logic [DW-1:0] beatData(input int b);
        logic [DW-1:0] d;
        for (int l = 0; l < 4; l++) d[l*2*NB +: 2*NB] = {NB'(l + 1), NB'(b)};
        return d;
    endfunction

    function automatic logic [OW-1:0] obsNow();
        return {s_ready, fftIn1_down, fftIn1_up, fftIn0_down, fftIn0_up, m_valid, m_sof, m_eof};
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; en = 1'b0; s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b1; s_valid = 1'b1; s_data = beatData(3);
        repeat (2) @(negedge clk);
        checks++;
        if (obsNow() !== '0) begin
            failures++;
            $display("FAIL reset_state obs=%h exp=0", obsNow());
        end
`ifdef FFT_FRAME_CTRL_STATUS_EN
        checks++;
        if (underrun !== 1'b0 || frame_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_status underrun=%b frame_cnt=%0d exp 0/0", underrun, frame_cnt);
        end
`endif
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obsNow() !== {1'b1, {DW{1'b0}}, 3'b000}) begin
            failures++;
            $display("FAIL reset_release obs=%h exp=%h", obsNow(), {1'b1, {DW{1'b0}}, 3'b000});
        end
        @(posedge clk); #1 s_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (obsNow() !== {1'b1, beatData(3), 3'b000}) begin
            failures++;
            $display("FAIL first_accept obs=%h exp=%h", obsNow(), {1'b1, beatData(3), 3'b000});
        end
    endtask

    task automatic test_single_frame();
        logic v;
        logic [DW-1:0] expIn;
        do_reset();
        for (int c = 0; c < 45; c++) begin
            @(posedge clk); #1;
            en = 1'b1; s_valid = (c < 32); s_data = beatData(c);
            @(negedge clk);
            expIn = (c >= 1 && c <= 32) ? beatData(c - 1) : '0;
            v = (c >= 8 && c <= 39);
            checks++;
            if (obsNow() !== {1'b1, expIn, v, c == 8, c == 39}) begin
                failures++;
                $display("FAIL single_frame c=%0d obs=%h exp=%h", c, obsNow(),
                         {1'b1, expIn, v, c == 8, c == 39});
            end
            if (v) begin
                checks++;
                if (m_data !== beatData(c - 8)) begin
                    failures++;
                    $display("FAIL single_mdata c=%0d got=%h exp=%h", c, m_data, beatData(c - 8));
                end
            end
        end
`ifdef FFT_FRAME_CTRL_STATUS_EN
        checks++;
        if (frame_cnt !== 16'd1 || underrun !== 1'b0) begin
            failures++;
            $display("FAIL single_status frame_cnt=%0d underrun=%b exp 1/0", frame_cnt, underrun);
        end
`endif
    endtask

    task automatic test_gap();
        logic v;
        logic [DW-1:0] expIn, expOut;
        do_reset();
        for (int c = 0; c < 45; c++) begin
            @(posedge clk); #1;
            en = 1'b1; s_valid = (c < 32) && !(c >= 10 && c <= 12); s_data = beatData(c);
            @(negedge clk);
            expIn = (c >= 1 && c <= 32 && !(c - 1 >= 10 && c - 1 <= 12)) ? beatData(c - 1) : '0;
            expOut = (c - 8 >= 10 && c - 8 <= 12) ? '0 : beatData(c - 8);
            v = (c >= 8 && c <= 39);
            checks++;
            if (obsNow() !== {1'b1, expIn, v, c == 8, c == 39}) begin
                failures++;
                $display("FAIL gap_frame c=%0d obs=%h exp=%h", c, obsNow(),
                         {1'b1, expIn, v, c == 8, c == 39});
            end
            if (v) begin
                checks++;
                if (m_data !== expOut) begin
                    failures++;
                    $display("FAIL gap_mdata c=%0d got=%h exp=%h", c, m_data, expOut);
                end
            end
`ifdef FFT_FRAME_CTRL_STATUS_EN
            checks++;
            if (underrun !== (c >= 11)) begin
                failures++;
                $display("FAIL gap_underrun c=%0d got=%b exp=%b", c, underrun, c >= 11);
            end
`endif
        end
`ifdef FFT_FRAME_CTRL_STATUS_EN
        checks++;
        if (frame_cnt !== 16'd1) begin
            failures++;
            $display("FAIL gap_frame_cnt got=%0d exp=1", frame_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic v, sof, eof;
        logic [DW-1:0] expIn;
        do_reset();
        for (int c = 0; c < 110; c++) begin
            @(posedge clk); #1;
            en = 1'b1; s_valid = (c < 96); s_data = beatData(c);
            @(negedge clk);
            expIn = (c >= 1 && c <= 96) ? beatData(c - 1) : '0;
            v = (c >= 8 && c <= 103);
            sof = v && ((c - 8) % 32 == 0);
            eof = v && ((c - 8) % 32 == 31);
            checks++;
            if (obsNow() !== {1'b1, expIn, v, sof, eof}) begin
                failures++;
                $display("FAIL b2b_frame c=%0d obs=%h exp=%h", c, obsNow(), {1'b1, expIn, v, sof, eof});
            end
            if (v) begin
                checks++;
                if (m_data !== beatData(c - 8)) begin
                    failures++;
                    $display("FAIL b2b_mdata c=%0d got=%h exp=%h", c, m_data, beatData(c - 8));
                end
            end
        end
`ifdef FFT_FRAME_CTRL_STATUS_EN
        checks++;
        if (frame_cnt !== 16'd3 || underrun !== 1'b0) begin
            failures++;
            $display("FAIL b2b_status frame_cnt=%0d underrun=%b exp 3/0", frame_cnt, underrun);
        end
`endif
    endtask

    task automatic test_enable();
        logic v, rdy;
        logic [DW-1:0] expIn;
        do_reset();
        for (int c = 0; c < 65; c++) begin
            @(posedge clk); #1;
            en = (c >= 20 && c <= 24); s_valid = 1'b1; s_data = beatData(c);
            @(negedge clk);
            rdy = (c >= 20 && c <= 51);
            expIn = (c >= 21 && c <= 52) ? beatData(c - 1) : '0;
            v = (c >= 28 && c <= 59);
            checks++;
            if (obsNow() !== {rdy, expIn, v, c == 28, c == 59}) begin
                failures++;
                $display("FAIL enable c=%0d obs=%h exp=%h", c, obsNow(), {rdy, expIn, v, c == 28, c == 59});
            end
            if (v) begin
                checks++;
                if (m_data !== beatData(c - 8)) begin
                    failures++;
                    $display("FAIL enable_mdata c=%0d got=%h exp=%h", c, m_data, beatData(c - 8));
                end
            end
        end
`ifdef FFT_FRAME_CTRL_STATUS_EN
        checks++;
        if (frame_cnt !== 16'd1) begin
            failures++;
            $display("FAIL enable_frame_cnt got=%0d exp=1", frame_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic v;
        logic [DW-1:0] expIn;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            en = 1'b1; s_valid = 1'b1; s_data = beatData(c);
            @(negedge clk);
            expIn = (c >= 1) ? beatData(c - 1) : '0;
            v = (c >= 8);
            checks++;
            if (obsNow() !== {1'b1, expIn, v, c == 8, 1'b0}) begin
                failures++;
                $display("FAIL rstmid_pre c=%0d obs=%h exp=%h", c, obsNow(), {1'b1, expIn, v, c == 8, 1'b0});
            end
        end
        @(posedge clk); #1;
        s_data = beatData(20);
        rst = 1'b1;
        #1;
        checks++;
        if (obsNow() !== '0) begin
            failures++;
            $display("FAIL rstmid_async obs=%h exp=0", obsNow());
        end
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 55; k++) begin
            @(posedge clk); #1;
            en = 1'b1; s_valid = (k >= 15 && k < 47); s_data = beatData(k);
            @(negedge clk);
            expIn = (k >= 16 && k <= 47) ? beatData(k - 1) : '0;
            v = (k >= 23 && k <= 54);
            checks++;
            if (obsNow() !== {1'b1, expIn, v, k == 23, k == 54}) begin
                failures++;
                $display("FAIL rstmid_post k=%0d obs=%h exp=%h", k, obsNow(),
                         {1'b1, expIn, v, k == 23, k == 54});
            end
            if (v) begin
                checks++;
                if (m_data !== beatData(k - 8)) begin
                    failures++;
                    $display("FAIL rstmid_mdata k=%0d got=%h exp=%h", k, m_data, beatData(k - 8));
                end
            end
        end
`ifdef FFT_FRAME_CTRL_STATUS_EN
        checks++;
        if (frame_cnt !== 16'd1 || underrun !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_status frame_cnt=%0d underrun=%b exp 1/0", frame_cnt, underrun);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_gap();
        test_back_to_back();
        test_enable();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
